// File: rtl/geo_sequence_checker_if.sv
// -----------------------------------------------------------------------------
// geo_sequence_checker_if
//
// Purpose:
//    Groups the round controller's player handshake, status flags and the
//    synchronous sequence ROM bus into one bundle. The controller connects
//    through the master modport; the game control unit, the button front end
//    and the ROM together form the slave side.
//
// Signals (direction seen from the master / round controller):
//    start         in   begin a round (honoured only while idle)
//    level         in   last sequence index to check, latched on start
//    jogada        in   player button vector, one-hot when valid
//    jogada_valid  in   single-cycle strobe qualifying jogada
//    rom_data      in   ROM read data, valid one cycle after rom_address
//    rom_address   out  ROM read address
//    busy          out  round in progress
//    ready         out  a press is being accepted
//    index         out  current position in the sequence
//    acertou       out  one-cycle pulse: whole round correct
//    errou         out  one-cycle pulse: wrong / non-one-hot / late press
//    timeout       out  one-cycle pulse alongside errou when the press window
//                       expired (present only with GEO_TIMEOUT_EN defined)
//
// Configuration macro: GEO_TIMEOUT_EN adds the timeout signal.
// -----------------------------------------------------------------------------
interface geo_sequence_checker_if #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
);
   logic              start;
   logic [ADDR_W-1:0] level;
   logic [DATA_W-1:0] jogada;
   logic              jogada_valid;
   logic [ADDR_W-1:0] rom_address;
   logic [DATA_W-1:0] rom_data;
   logic              busy;
   logic              ready;
   logic [ADDR_W-1:0] index;
   logic              acertou;
   logic              errou;
`ifdef GEO_TIMEOUT_EN
   logic              timeout;
`endif

   modport master (
      input  start, level, jogada, jogada_valid, rom_data,
      output rom_address, busy, ready, index, acertou, errou
`ifdef GEO_TIMEOUT_EN
      , output timeout
`endif
   );

   modport slave (
      output start, level, jogada, jogada_valid, rom_data,
      input  rom_address, busy, ready, index, acertou, errou
`ifdef GEO_TIMEOUT_EN
      , input timeout
`endif
   );
endinterface

// File: rtl/geo_sequence_checker.sv
// -----------------------------------------------------------------------------
// geo_sequence_checker
//
// Purpose:
//    Round controller sitting directly behind the 2^ADDR_W x DATA_W
//    synchronous sequence ROM. For each index 0..level it fetches the stored
//    one-hot entry, waits for the player's press and compares the two. The
//    round ends with a single-cycle acertou (every press matched) or errou
//    (first mismatch, non-one-hot press, or an expired press window).
//
// Ports:
//    clock    in   system clock, rising edge
//    reset_n  in   asynchronous reset, active low
//    bus      geo_sequence_checker_if.master
//                  start/level/jogada/jogada_valid from the game side,
//                  rom_address/rom_data to the ROM, busy/ready/index/
//                  acertou/errou (and timeout) status back to the game side.
//
// Parameters:
//    ADDR_W          ROM address width (sequence length 2^ADDR_W)
//    DATA_W          ROM word / button vector width
//    TIMEOUT_CYCLES  cycles allowed per press (GEO_TIMEOUT_EN only)
//
// Configuration macro:
//    GEO_TIMEOUT_EN  when defined, a press window of TIMEOUT_CYCLES cycles is
//                    enforced in WAIT and the timeout output is added. When
//                    undefined, WAIT holds indefinitely.
//
// Timing (cycle 0 = edge that samples the event):
//    start at cycle 0     -> ready high at cycle 3
//    press at cycle t     -> acertou/errou at t+2, or ready again at t+4
// -----------------------------------------------------------------------------
module geo_sequence_checker #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
`ifdef GEO_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 1000
`endif
) (
   input  logic                          clock,
   input  logic                          reset_n,
   geo_sequence_checker_if.master        bus
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      WAIT,
      CHECK
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] level_q, level_d;
   logic [ADDR_W-1:0] index_q, index_d;
   logic [ADDR_W-1:0] rom_address_q, rom_address_d;
   logic [DATA_W-1:0] expected_q, expected_d;
   logic [DATA_W-1:0] jogada_q, jogada_d;
   logic              busy_q, busy_d;
   logic              ready_q, ready_d;
   logic              acertou_q, acertou_d;
   logic              errou_q, errou_d;
   logic              match;

`ifdef GEO_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             timeout_q, timeout_d;
   logic             expired;

   assign expired = (wait_cnt_q == CNT_LAST);
`endif

   // A press counts only when it is a genuine one-hot vector; the all-zero
   // vector and multi-button presses fail even if the stored word matches.
   function automatic logic is_one_hot(input logic [DATA_W-1:0] v);
      return (v != '0) && ((v & (v - DATA_W'(1))) == '0);
   endfunction

   assign match = (jogada_q == expected_q) && is_one_hot(jogada_q);

   // ------------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned; a missing default here would infer a latch.
      state_d       = state_q;
      level_d       = level_q;
      index_d       = index_q;
      rom_address_d = rom_address_q;
      expected_d    = expected_q;
      jogada_d      = jogada_q;
      acertou_d     = 1'b0;
      errou_d       = 1'b0;
`ifdef GEO_TIMEOUT_EN
      timeout_d     = 1'b0;
`endif

      unique case (state_q)
         IDLE: begin
            // jogada_valid is deliberately not looked at here.
            if (bus.start) begin
               level_d       = bus.level;
               index_d       = '0;
               rom_address_d = '0;
               state_d       = FETCH;
            end
         end

         // The address register is loaded on the transition into FETCH, so
         // the ROM sees the new address for the whole FETCH cycle and its
         // registered output is valid throughout LOAD.
         FETCH: state_d = LOAD;

         LOAD: begin
            expected_d = bus.rom_data;
            state_d    = WAIT;
         end

         WAIT: begin
            // A press on the expiry cycle takes priority over the timeout.
            if (bus.jogada_valid) begin
               jogada_d = bus.jogada;
               state_d  = CHECK;
            end
`ifdef GEO_TIMEOUT_EN
            else if (expired) begin
               errou_d   = 1'b1;
               timeout_d = 1'b1;
               state_d   = IDLE;
            end
`endif
         end

         CHECK: begin
            if (!match) begin
               // index is left at the failing position for the game unit.
               errou_d = 1'b1;
               state_d = IDLE;
            end else if (index_q == level_q) begin
               // Completion is decided before any increment, so level at
               // the top index finishes without index wrapping to zero.
               acertou_d = 1'b1;
               state_d   = IDLE;
            end else begin
               index_d       = index_q + ADDR_W'(1);
               rom_address_d = index_q + ADDR_W'(1);
               state_d       = FETCH;
            end
         end

         default: state_d = IDLE;
      endcase

      // Status flags follow the state being entered so they are registered
      // and line up exactly with the state they describe.
      busy_d  = (state_d != IDLE);
      ready_d = (state_d == WAIT);

`ifdef GEO_TIMEOUT_EN
      // Zero outside WAIT, so the count restarts on every entry to WAIT.
      wait_cnt_d = (state_q == WAIT) ? wait_cnt_q + CNT_W'(1) : '0;
`endif
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before the edge, independent of statement
   // order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         level_q       <= '0;
         index_q       <= '0;
         rom_address_q <= '0;
         expected_q    <= '0;
         jogada_q      <= '0;
         busy_q        <= 1'b0;
         ready_q       <= 1'b0;
         acertou_q     <= 1'b0;
         errou_q       <= 1'b0;
`ifdef GEO_TIMEOUT_EN
         wait_cnt_q    <= '0;
         timeout_q     <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         level_q       <= level_d;
         index_q       <= index_d;
         rom_address_q <= rom_address_d;
         expected_q    <= expected_d;
         jogada_q      <= jogada_d;
         busy_q        <= busy_d;
         ready_q       <= ready_d;
         acertou_q     <= acertou_d;
         errou_q       <= errou_d;
`ifdef GEO_TIMEOUT_EN
         wait_cnt_q    <= wait_cnt_d;
         timeout_q     <= timeout_d;
`endif
      end
   end

   // ------------------------------------------------------------------------
   // Outputs (all straight from flops)
   // ------------------------------------------------------------------------
   assign bus.rom_address = rom_address_q;
   assign bus.busy        = busy_q;
   assign bus.ready       = ready_q;
   assign bus.index       = index_q;
   assign bus.acertou     = acertou_q;
   assign bus.errou       = errou_q;
`ifdef GEO_TIMEOUT_EN
   assign bus.timeout     = timeout_q;
`endif

endmodule

// File: doc/geo_sequence_checker.md
Name: geo_sequence_checker

Overview:
- Round controller directly downstream of the 8x8 synchronous sequence ROM.
- Drives the ROM address, captures each stored one-hot entry and waits for the player's one-hot button press (jogada).
- Compares each press with the stored entry, one index at a time from 0 up to a latched level.
- Reports a single-cycle acertou (whole round correct) or errou (first mismatch) pulse to the game control unit.

Parameters:
- ADDR_W, 3, ROM address width; the sequence holds 2^ADDR_W entries.
- DATA_W, 8, ROM word width and button vector width.
- TIMEOUT_CYCLES, 1000, cycles allowed per press. Used only with GEO_TIMEOUT_EN.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous reset, active low.
- start  in  1  starts a round; sampled only in IDLE.
- level  in  ADDR_W  last index to check; latched on an accepted start.
- jogada  in  DATA_W  button vector; must be one-hot to count as correct.
- jogada_valid  in  1  single-cycle strobe qualifying jogada.
- rom_address  out  ADDR_W  address to the ROM.
- rom_data  in  DATA_W  ROM data_out; valid one cycle after rom_address.
- busy  out  1  high in every state except IDLE.
- ready  out  1  high only in WAIT (a press is accepted).
- index  out  ADDR_W  current position in the sequence.
- acertou  out  1  one-cycle pulse: round completed correctly.
- errou  out  1  one-cycle pulse: wrong, non-one-hot, or timed-out press.

Behaviour:
- Clock and reset: all state on posedge clock. reset_n low asynchronously forces IDLE, including mid-round.
- Reset values: rom_address=0, index=0, expected=0, busy=0, ready=0, acertou=0, errou=0.
- All outputs are registered.
- FSM states: IDLE, FETCH, LOAD, WAIT, CHECK.
  - IDLE: start=1 latches level, sets index=0, goes to FETCH.
  - FETCH: rom_address=index; go to LOAD. This cycle covers the ROM's one-cycle read latency.
  - LOAD: expected <= rom_data; go to WAIT.
  - WAIT: ready=1. On jogada_valid, register jogada and go to CHECK. Without jogada_valid, stay.
  - CHECK:
    - Match means registered jogada == expected, exactly one bit set, and not zero.
    - Match and index==level: acertou pulse, go to IDLE.
    - Match and index<level: index+1, go to FETCH.
    - Mismatch: errou pulse, go to IDLE, index holds the failing position.
- Latency:
  - start sampled at cycle 0 → ready high at cycle 3.
  - Press sampled at cycle t → acertou/errou high at cycle t+2, or ready again at t+4 when correct and not last.
- Boundaries:
  - level=0: a single press decides the round.
  - level=2^ADDR_W-1: index reaches max and never wraps. Completion is detected by equality before any increment.
  - jogada_valid outside WAIT is ignored and not buffered.
  - start while busy is ignored; level changes while busy are ignored.
  - start and jogada_valid in the same IDLE cycle: only start acts.
  - acertou and errou are never high together and never high two cycles in a row.

Optional Feature:
- Macro GEO_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each cycle in WAIT.
  - When it reaches TIMEOUT_CYCLES-1 with no jogada_valid, go to IDLE and pulse errou.
  - Extra output port timeout (1 bit) is high on the same cycle as that errou and cleared at reset.
  - If jogada_valid arrives in the same cycle as expiry, the press wins.
- Undefined: no counter and no timeout port; WAIT holds indefinitely.

Test Plan:
- Correct round: ROM k→1<<k, level=2, presses 0x01, 0x02, 0x04 → rom_address steps 0,1,2; acertou=1 for one cycle; index=2; busy falls the next cycle.
- Wrong press: level=3, presses 0x01 then 0x08 → errou pulse two cycles after the second press; index=1; no acertou.
- Non-one-hot press: level=0, press 0x03, and separately 0x00 → errou each time.
- Full sequence: level=7, all eight correct presses 0x01..0x80 → acertou; index=7 (no wrap); ready low between presses for 3 cycles.
- Reset mid-round: assert reset_n=0 while in WAIT at index=4 → immediately busy=0, ready=0, index=0; a following start restarts at address 0.
- Timeout (GEO_TIMEOUT_EN, TIMEOUT_CYCLES=16): no press → errou and timeout high 16 cycles after ready rises. A press on the expiry cycle → normal compare, no timeout.
